// File: rtl/seq_shift_unit.sv
// seq_shift_unit: multi-cycle shift/rotate unit (SLL, SRL, SRA, ROR).
// An operand is captured on a start request and shifted by up to STEP
// positions per clock until the requested amount has been consumed. The
// start/busy/done handshake matches the multiply/divide unit so the pipeline
// can stall on it the same way.

module seq_shift_unit #(
    parameter int WIDTH = 32,
    parameter int STEP  = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [1:0]                 op,
    input  logic [WIDTH-1:0]           data,
    input  logic [$clog2(WIDTH)-1:0]   shamt,
    output logic                       busy,
    output logic                       done,
    output logic [WIDTH-1:0]           result
);

    localparam int SHW = $clog2(WIDTH);

    localparam logic STATE_IDLE = 1'b0;
    localparam logic STATE_RUN  = 1'b1;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;

    // Counter-width copies of the step size and data width. The remaining
    // count is one bit wider than shamt so STEP == WIDTH fits as well.
    localparam logic [SHW:0] C_STEP  = (SHW+1)'(STEP);
    localparam logic [SHW:0] C_WIDTH = (SHW+1)'(WIDTH);

    logic             r_state;
    logic [WIDTH-1:0] r_acc;
    logic [SHW:0]     r_rem;
    logic [1:0]       r_op;
    logic [WIDTH-1:0] r_result;
    logic             r_done;

    logic [SHW:0]     w_k;
    logic [SHW:0]     w_rorBack;
    logic [SHW:0]     w_remNext;
    logic [WIDTH-1:0] w_shifted;
    logic             w_lastStep;

    // Positions applied this cycle: the full step, or whatever is left.
    always_comb begin
        w_k       = (r_rem < C_STEP) ? r_rem : C_STEP;
        w_remNext = r_rem - w_k;
        w_lastStep = (w_remNext == '0);
        w_rorBack = C_WIDTH - w_k;
    end

    // One step of the selected shift; a zero step leaves acc unchanged
    // (for ROR the left shift by WIDTH yields zero, so the OR is a no-op).
    always_comb begin
        w_shifted = r_acc;
        case (r_op)
            OP_SLL:  w_shifted = r_acc << w_k;
            OP_SRL:  w_shifted = r_acc >> w_k;
            OP_SRA:  w_shifted = $unsigned($signed(r_acc) >>> w_k);
            OP_ROR:  w_shifted = (r_acc >> w_k) | (r_acc << w_rorBack);
            default: w_shifted = r_acc;
        endcase
    end

    // Control and datapath registers: accept in IDLE, step in RUN, publish
    // the result and a one-cycle done pulse on the final step.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state  <= STATE_IDLE;
            r_acc    <= '0;
            r_rem    <= '0;
            r_op     <= OP_SLL;
            r_result <= '0;
            r_done   <= 1'b0;
        end else begin
            case (r_state)
                STATE_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_acc   <= data;
                        r_rem   <= {1'b0, shamt};
                        r_op    <= op;
                        r_state <= STATE_RUN;
                    end
                end
                STATE_RUN: begin
                    r_acc <= w_shifted;
                    r_rem <= w_remNext;
                    if (w_lastStep) begin
                        r_result <= w_shifted;
                        r_done   <= 1'b1;
                        r_state  <= STATE_IDLE;
                    end else begin
                        r_done <= 1'b0;
                    end
                end
                default: begin
                    r_done  <= 1'b0;
                    r_state <= STATE_IDLE;
                end
            endcase
        end
    end

    assign busy   = (r_state == STATE_RUN);
    assign done   = r_done;
    assign result = r_result;

endmodule

// File: tb/tb_seq_shift_unit.sv
// tb_seq_shift_unit: directed handshake/reset scenarios on a STEP=4 unit,
// followed by a randomized sweep of all ops and amounts on STEP=1/4/32
// units sharing the same inputs.

module tb_seq_shift_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] data;
    logic [4:0]  shamt;

    logic        busyA [3];
    logic        doneA [3];
    logic [31:0] resA  [3];

    int checks;
    int failures;

    seq_shift_unit #(.WIDTH(32), .STEP(1)) u_step1 (
        .clk(clk), .reset(reset), .start(start), .op(op), .data(data),
        .shamt(shamt), .busy(busyA[0]), .done(doneA[0]), .result(resA[0])
    );

    seq_shift_unit #(.WIDTH(32), .STEP(4)) u_step4 (
        .clk(clk), .reset(reset), .start(start), .op(op), .data(data),
        .shamt(shamt), .busy(busyA[1]), .done(doneA[1]), .result(resA[1])
    );

    seq_shift_unit #(.WIDTH(32), .STEP(32)) u_step32 (
        .clk(clk), .reset(reset), .start(start), .op(op), .data(data),
        .shamt(shamt), .busy(busyA[2]), .done(doneA[2]), .result(resA[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: each output bit is picked from its source input bit.
    function automatic logic [31:0] refShift(input logic [1:0] o, input logic [31:0] d, input int sh);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            case (o)
                2'd0:    r[i] = (i >= sh) ? d[i - sh] : 1'b0;
                2'd1:    r[i] = (i + sh < 32) ? d[i + sh] : 1'b0;
                2'd2:    r[i] = (i + sh < 32) ? d[i + sh] : d[31];
                default: r[i] = d[(i + sh) % 32];
            endcase
        end
        return r;
    endfunction

    function automatic int refLatency(input int sh, input int step);
        if (sh == 0) return 1;
        return (sh + step - 1) / step;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // Present a request at a falling edge and drop start after the next rising edge.
    task automatic applyStimulus(input logic [1:0] o, input logic [31:0] d, input logic [4:0] s);
        @(negedge clk);
        op    = o;
        data  = d;
        shamt = s;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Wait for done on the STEP=4 unit, counting busy cycles; optionally
    // pulse a start (which must be ignored) at the given busy cycle index.
    task automatic waitDone(input int injectAt, output int busyCycles, output logic [31:0] res);
        logic gotDone;
        gotDone    = 1'b0;
        busyCycles = 0;
        res        = '0;
        for (int c = 0; c < 64; c++) begin
            @(negedge clk);
            if (c == injectAt + 1) start = 1'b0;
            if (doneA[1]) begin
                gotDone = 1'b1;
                res     = resA[1];
                break;
            end
            if (busyA[1]) busyCycles++;
            if (c == injectAt) begin
                op    = 2'd1;
                data  = 32'hFFFF_FFFF;
                shamt = 5'd3;
                start = 1'b1;
            end
        end
        start = 1'b0;
        checkOutput("done_seen", {31'b0, gotDone}, 32'd1);
    endtask

    initial begin
        int          bc;
        logic [31:0] res;
        logic [31:0] d;
        logic [31:0] expV;
        logic        seen [3];
        int          cnt  [3];
        logic [31:0] got  [3];
        int          stepOf [3];

        stepOf   = '{1, 4, 32};
        checks   = 0;
        failures = 0;
        reset    = 1'b0;
        start    = 1'b0;
        op       = 2'd0;
        data     = '0;
        shamt    = '0;

        // Reset state
        repeat (2) @(negedge clk);
        checkOutput("reset_busy", {31'b0, busyA[1]}, 32'd0);
        checkOutput("reset_done", {31'b0, doneA[1]}, 32'd0);
        checkOutput("reset_result", resA[1], 32'd0);
        reset = 1'b1;

        // SRA, one step
        applyStimulus(2'd2, 32'h8000_00F0, 5'd4);
        waitDone(-1, bc, res);
        checkOutput("sra_result", res, 32'hF800_000F);
        checkOutput("sra_busy", 32'(bc), 32'd1);

        // SRL, same operands
        applyStimulus(2'd1, 32'h8000_00F0, 5'd4);
        waitDone(-1, bc, res);
        checkOutput("srl_result", res, 32'h0800_000F);

        // SLL by 31: eight steps, single done pulse
        applyStimulus(2'd0, 32'h0000_0001, 5'd31);
        waitDone(-1, bc, res);
        checkOutput("sll31_result", res, 32'h8000_0000);
        checkOutput("sll31_busy", 32'(bc), 32'd8);
        @(negedge clk);
        checkOutput("sll31_done_pulse", {31'b0, doneA[1]}, 32'd0);

        // ROR by 4 and ROR by 0
        applyStimulus(2'd3, 32'h0000_00F1, 5'd4);
        waitDone(-1, bc, res);
        checkOutput("ror4_result", res, 32'h1000_000F);
        applyStimulus(2'd3, 32'h1234_5678, 5'd0);
        waitDone(-1, bc, res);
        checkOutput("ror0_result", res, 32'h1234_5678);
        checkOutput("ror0_busy", 32'(bc), 32'd1);

        // start while busy is ignored
        applyStimulus(2'd0, 32'h0000_0001, 5'd31);
        waitDone(2, bc, res);
        checkOutput("ignored_result", res, 32'h8000_0000);
        checkOutput("ignored_busy", 32'(bc), 32'd8);
        @(negedge clk);
        checkOutput("ignored_no_restart", {31'b0, busyA[1]}, 32'd0);

        // start in the done cycle is accepted; old result held until completion
        applyStimulus(2'd1, 32'h8000_0000, 5'd8);
        waitDone(-1, bc, res);
        checkOutput("b2b_first_result", res, 32'h0080_0000);
        op    = 2'd0;
        data  = 32'h0000_0003;
        shamt = 5'd4;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        checkOutput("b2b_busy", {31'b0, busyA[1]}, 32'd1);
        checkOutput("b2b_held", resA[1], 32'h0080_0000);
        waitDone(-1, bc, res);
        checkOutput("b2b_second_result", res, 32'h0000_0030);

        // Reset in the third RUN cycle, with start held during reset
        applyStimulus(2'd0, 32'h0000_0001, 5'd31);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        start = 1'b1;
        data  = 32'hFFFF_FFFF;
        @(negedge clk);
        checkOutput("abort_busy", {31'b0, busyA[1]}, 32'd0);
        checkOutput("abort_done", {31'b0, doneA[1]}, 32'd0);
        checkOutput("abort_result", resA[1], 32'd0);
        @(negedge clk);
        checkOutput("reset_start_ignored", {31'b0, busyA[1]}, 32'd0);
        reset = 1'b1;
        start = 1'b0;
        applyStimulus(2'd2, 32'hF000_0000, 5'd8);
        waitDone(-1, bc, res);
        checkOutput("post_reset_result", res, 32'hFFF0_0000);
        checkOutput("post_reset_busy", 32'(bc), 32'd2);

        // Bring all three units to a common idle point
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;

        // Randomized sweep: every op and amount on STEP=1/4/32
        for (int o = 0; o < 4; o++) begin
            for (int s = 0; s < 32; s++) begin
                d = $urandom;
                applyStimulus(o[1:0], d, s[4:0]);
                for (int j = 0; j < 3; j++) begin
                    seen[j] = 1'b0;
                    cnt[j]  = 0;
                    got[j]  = '0;
                end
                for (int c = 0; c < 40; c++) begin
                    @(negedge clk);
                    for (int j = 0; j < 3; j++) begin
                        if (!seen[j]) begin
                            if (doneA[j]) begin
                                seen[j] = 1'b1;
                                got[j]  = resA[j];
                            end else if (busyA[j]) begin
                                cnt[j]++;
                            end
                        end
                    end
                    if (seen[0] && seen[1] && seen[2]) break;
                end
                expV = refShift(o[1:0], d, s);
                for (int j = 0; j < 3; j++) begin
                    checkOutput($sformatf("sweep_done op%0d sh%0d step%0d", o, s, stepOf[j]),
                                {31'b0, seen[j]}, 32'd1);
                    checkOutput($sformatf("sweep_result op%0d sh%0d step%0d", o, s, stepOf[j]),
                                got[j], expV);
                    checkOutput($sformatf("sweep_busy op%0d sh%0d step%0d", o, s, stepOf[j]),
                                32'(cnt[j]), 32'(refLatency(s, stepOf[j])));
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seq_shift_unit.md
Name: seq_shift_unit

Overview:
- Parametrised multi-cycle shift/rotate unit for the ALU/MDU side of the CPU datapath.
- Successor to the single-cycle combinational shift checks: it adds SLL/SRL/SRA/ROR modes, configurable width, and a configurable number of bits shifted per cycle.
- Uses a start/busy/done handshake so the pipeline can stall on it the same way it stalls on the multiply/divide unit.

Parameters:
- WIDTH, 32, data width in bits; power of 2, ≥2.
- STEP, 4, maximum bits shifted per clock; power of 2, 1..WIDTH.
- SHW, $clog2(WIDTH), shift-amount width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset (0 = reset).
- start  input  1  request; accepted only when busy=0.
- op  input  2  00 SLL, 01 SRL, 10 SRA, 11 ROR (rotate right).
- data  input  WIDTH  operand; sampled at acceptance.
- shamt  input  SHW  shift amount 0..WIDTH-1; sampled at acceptance.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse; result is valid.
- result  output  WIDTH  registered result; held until the next acceptance or reset.

Behaviour:
- States: IDLE and RUN. Registers: state, acc (WIDTH), rem (SHW+1), op_r, result, done.
- Reset (reset=0 at a rising edge): state=IDLE, busy=0, done=0, result=0, acc=0, rem=0.
  - Reset overrides everything else. It aborts an operation in RUN with no done pulse.
  - start is ignored in any cycle where reset=0.
- IDLE:
  - If start=1 at an edge: acc<=data, rem<=shamt, op_r<=op, state<=RUN.
  - done<=0 on every edge not completing an operation.
- RUN:
  - Each edge applies k=min(STEP, rem) positions to acc according to op_r, then rem<=rem-k.
  - SLL: zero fill from the LSB end.
  - SRL: zero fill from the MSB end.
  - SRA: MSB replicated; the sign is taken from the current acc MSB, which equals the original sign.
  - ROR: bits leaving the LSB re-enter at the MSB.
  - When the post-step rem is 0: result<=shifted acc, done<=1, state<=IDLE.
- shamt=0 still takes one RUN edge with a zero shift; result=data.
- Latency: N = max(1, ceil(shamt/STEP)) edges from the acceptance edge to the edge that sets done.
  - busy=1 (state==RUN) for exactly N cycles.
  - done=1 in the single cycle after the final RUN edge.
- busy is combinational from state. done and result are registered.
- start while busy=1 is ignored; no queueing, no error flag.
- start=1 in the same cycle done=1 (state is already IDLE) is accepted.
  - The new operation begins normally.
  - result keeps the completed value until the new operation finishes.
- result changes only on completion or reset, never mid-RUN.
- The intermediate acc is not visible on any port.
- op, data and shamt are don't-care except at the acceptance edge.
- All arithmetic is unsigned except the SRA fill. No overflow or carry outputs.

Test Plan:
- Setup for all scenarios: WIDTH=32, STEP=4.
- SRA: data=0x8000_00F0, shamt=4 -> done after 1 edge, result=0xF800_000F, busy high for 1 cycle.
- SRL, same operands -> result=0x0800_000F; SLL data=0x0000_0001, shamt=31 -> result=0x8000_0000, busy high exactly 8 cycles, single done pulse.
- ROR: data=0x0000_00F1, shamt=4 -> result=0x1000_000F. shamt=0, op=ROR, data=0x1234_5678 -> result=0x1234_5678, latency 1.
- Handshake:
  - During a 31-bit SLL, pulse start with data=0xFFFF_FFFF; it is ignored and result is still 0x8000_0000.
  - start asserted in the done cycle is accepted; busy goes high at the next edge and the old result is held until the new completion.
- Reset mid-operation: reset=0 at the 3rd RUN cycle -> next edge busy=0, done=0, result=0.
  - start held high while reset=0 is not accepted.
  - After reset releases, a new request completes normally.
- Sweep: all ops × shamt 0..31 × STEP∈{1,4,32} with random data.
  - result must equal the reference shift/rotate.
  - busy must last max(1, ceil(shamt/STEP)) cycles.
